// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage: fetches over a req/ack handshake and
// selects the next PC from the control unit's decisions when EXEC retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opc,
    output logic [5:0]  func,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        isJmp,
    input  logic        isBeq,
    input  logic        isBne,
    input  logic        invOpcode,
    input  logic        aluZero,
    input  logic        exec_hold,
    output logic        halted
);

    typedef enum logic [1:0] {StReset, StFetch, StExec, StTrap} fetchStateT;

    fetchStateT  stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] instrQ, instrD;
    logic [31:0] pcPlus4, jmpTarget, brTarget, nextPc;
    logic        brTaken;

    // Next-PC candidates; invOpcode is handled by the FSM (PC simply holds).
    always_comb begin
        pcPlus4   = pcQ + 32'd4;
        jmpTarget = {pcPlus4[31:28], instrQ[25:0], 2'b00};
        brTarget  = pcPlus4 + {{14{instrQ[15]}}, instrQ[15:0], 2'b00};
        brTaken   = (isBeq & aluZero) | (isBne & ~aluZero);
        if (isJmp) begin
            nextPc = jmpTarget;
        end else if (brTaken) begin
            nextPc = brTarget;
        end else begin
            nextPc = pcPlus4;
        end
    end

    always_comb begin
        stateD = stateQ;
        pcD    = pcQ;
        instrD = instrQ;
        unique case (stateQ)
            StReset: stateD = StFetch;
            StFetch: begin
                if (imem_ack) begin
                    instrD = imem_rdata;
                    stateD = StExec;
                end
            end
            StExec: begin
                if (!exec_hold) begin
                    if (invOpcode) begin
                        stateD = StTrap;
                    end else begin
                        pcD    = nextPc;
                        stateD = StFetch;
                    end
                end
            end
            StTrap: stateD = StTrap;
            default: stateD = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StReset;
            pcQ    <= RESET_PC;
            instrQ <= 32'd0;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            instrQ <= instrD;
        end
    end

    // Handshake/status outputs come straight from the state register.
    assign imem_req    = (stateQ == StFetch);
    assign instr_valid = (stateQ == StExec);
    assign halted      = (stateQ == StTrap);
    assign imem_addr   = pcQ;
    assign pc          = pcQ;
    assign pc_plus4    = pcPlus4;
    assign instr       = instrQ;
    assign opc         = instrQ[31:26];
    assign func        = instrQ[5:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC-sequencing stage of the MIPS32 SOC datapath. Holds the program counter, fetches each instruction word from instruction memory over a request/acknowledge handshake, and presents it in an instruction register whose `opc` and `func` fields drive the control unit. During the execute cycle it consumes the control unit's `isJmp`, `isBeq`, `isBne` and `invOpcode` outputs, plus the ALU zero flag, to select the next PC. An invalid instruction halts the stage until reset.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC after reset; must be word-aligned.

- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_addr`  out  32  byte address of the instruction being fetched; equals `pc`.
- `imem_req`  out  1  fetch request.
- `imem_ack`  in  1  instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  instruction register.
- `opc`  out  6  `instr[31:26]`, to the control unit.
- `func`  out  6  `instr[5:0]`, to the control unit.
- `instr_valid`  out  1  high in EXEC: `instr` is being executed.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `isJmp`, `isBeq`, `isBne`, `invOpcode`  in  1 each  control unit outputs; sampled only in EXEC.
- `aluZero`  in  1  ALU zero flag for the instruction in EXEC.
- `exec_hold`  in  1  extends EXEC (datapath busy, e.g. multi-cycle data access).
- `halted`  out  1  stage is in TRAP.

## Operation
- States: RESET, FETCH, EXEC, TRAP.
- RESET: entered asynchronously while `rst_n`=0; `pc`=RESET_PC, `instr`=0, `imem_req`=0, `instr_valid`=0, `halted`=0. First edge after deassertion -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, both stable until the ack cycle inclusive. On a cycle with `imem_ack`=1: `instr`<=`imem_rdata`, -> EXEC. `imem_ack` outside FETCH is ignored.
- EXEC: `instr_valid`=1, `imem_req`=0. If `exec_hold`=1: stay in EXEC, `pc` and `instr` unchanged. Else update `pc` with the next-PC rule, then -> FETCH; if `invOpcode`=1, -> TRAP instead.
- Next-PC priority (highest first):
  - `invOpcode`: `pc` unchanged.
  - `isJmp`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `(isBeq & aluZero) | (isBne & ~aluZero)`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Otherwise: `pc_plus4`.
- All PC arithmetic is 32-bit and wraps modulo 2^32. `pc[1:0]` is always 00.
- TRAP: `halted`=1, `imem_req`=0, `instr_valid`=0. `pc` and `instr` hold the faulting instruction. Exit only through reset.

## Timing
- Minimum two cycles per instruction: the FETCH cycle in which ack is seen, then one EXEC cycle.
- Zero-wait memory: `imem_req` is asserted in cycle N, `imem_ack`=1 in cycle N, `instr_valid`=1 in cycle N+1, `imem_req`=1 with the new address in cycle N+2.
- Each cycle of ack delay adds one FETCH cycle. Each cycle of `exec_hold` adds one EXEC cycle.
- Control inputs and `aluZero` are sampled on the EXEC edge that exits EXEC (the edge where `exec_hold`=0).
- `imem_req`, `instr_valid` and `halted` are decoded from the state register and are glitch-free.
- Reset during FETCH: the request is dropped immediately. A late ack arriving in RESET is discarded, and the fetch restarts at RESET_PC.
- Simultaneous `isJmp` and branch: the jump wins. `invOpcode` overrides everything.

## Test plan
- Sequential execution: release reset, zero-wait memory, three ADDs. Required: `imem_addr` = 0x00400000, then 0x00400004, then 0x00400008. `instr_valid` pulses every 2nd cycle and `opc`/`func` match each word.
- Jump: at `pc`=0x00400008, `instr`=0x08100010, `isJmp`=1. Required: next `imem_addr` = 0x00400040.
- Branches at `pc`=0x00400010:
  - imm 0xFFFF, `isBeq`=1, `aluZero`=1 -> next `pc` = 0x00400010.
  - Same with `aluZero`=0 -> 0x00400014.
  - imm 0x0003, `isBne`=1, `aluZero`=0 -> 0x00400020.
- Stalls: ack delayed 3 cycles. Required: `imem_req` and `imem_addr` stable for 4 cycles. Then `exec_hold`=1 for 2 cycles. Required: `instr_valid` high for 3 cycles, `pc` unchanged until the exit edge.
- Trap: `invOpcode`=1 in EXEC at 0x00400004. Required: `halted`=1, `imem_req`=0 for 10+ cycles, `pc`=0x00400004. Pulse `rst_n` low. Required: fetch resumes at 0x00400000 with `halted`=0.
- Edge cases:
  - `rst_n` low mid-FETCH with ack one cycle later. Required: `imem_req`=0 immediately, ack ignored.
  - `RESET_PC`=0xFFFFFFFC, sequential instruction. Required: next `imem_addr` = 0x00000000.
